// File: rtl/divider_pkg.sv
// Shared types and constants for the divider scheduler.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned MIN_DIV = 1;

endpackage

// File: rtl/divider_scheduler_if.sv
// Divisor request channels for the host path (A) and the sweep engine (B).
interface divider_scheduler_if #(
   parameter int unsigned BITS = 8
);
   logic            a_valid;
   logic [BITS-1:0] a_divisor;
   logic            a_ready;
   logic            b_valid;
   logic [BITS-1:0] b_divisor;
   logic            b_ready;

   modport master (
      output a_valid, a_divisor, b_valid, b_divisor,
      input  a_ready, b_ready
   );

   modport slave (
      input  a_valid, a_divisor, b_valid, b_divisor,
      output a_ready, b_ready
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the other side after each grant.
module rr_arb2 (
   input  logic       clock_in,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       enable,
   output logic [1:0] grant
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (valid == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
         end else begin
            grant = valid;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant[0]) begin
         ptr_d = 1'b1;
      end else if (grant[1]) begin
         ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/divider_scheduler.sv
// Starts/stops the shared clock divider and applies arbitrated divisor updates
// only at divider output rising edges.
module divider_scheduler
   import divider_pkg::*;
#(
   parameter int unsigned BITS        = 8,
   parameter int unsigned DEFAULT_DIV = 1,
   parameter int unsigned BURST_BITS  = 16
) (
   input  logic                  clock_in,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic [BURST_BITS-1:0] burst_len,
   input  logic                  div_clk,
   divider_scheduler_if.slave    req,
   output logic [BITS-1:0]       divisor_out,
   output logic                  div_reset_n,
   output logic                  busy,
   output logic                  pending,
   output logic                  done
);

   state_t                state_q, state_d;
   logic                  div_clk_q;
   logic [BITS-1:0]       divisor_q, divisor_d;
   logic [BITS-1:0]       shadow_q, shadow_d;
   logic                  pending_q, pending_d;
   logic [BURST_BITS-1:0] burst_cnt_q, burst_cnt_d;
   logic                  cont_q, cont_d;
   logic                  div_reset_n_q, div_reset_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  rise;
   logic                  arb_en;
   logic [1:0]            grant;
   logic                  acc;
   logic [BITS-1:0]       req_div;
   logic [BITS-1:0]       acc_div;

   assign rise    = div_clk & ~div_clk_q;
   // Requests are refused while a shadowed divisor is still waiting for its edge.
   assign arb_en  = reset & ((state_q == IDLE) | ~pending_q);
   assign acc     = |grant;
   assign req_div = grant[1] ? req.b_divisor : req.a_divisor;
   assign acc_div = (req_div == '0) ? BITS'(MIN_DIV) : req_div;

   assign req.a_ready = grant[0];
   assign req.b_ready = grant[1];

   rr_arb2 u_arb (
      .clock_in (clock_in),
      .reset    (reset),
      .valid    ({req.b_valid, req.a_valid}),
      .enable   (arb_en),
      .grant    (grant)
   );

   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      divisor_d   = divisor_q;
      shadow_d    = shadow_q;
      pending_d   = pending_q;
      burst_cnt_d = burst_cnt_q;
      cont_d      = cont_q;

      case (state_q)
         IDLE: begin
            if (acc) begin
               divisor_d = acc_div;
            end
            if (start && !stop) begin
               burst_cnt_d = burst_len;
               cont_d      = (burst_len == '0);
               state_d     = RUN;
            end
         end
         RUN: begin
            if (rise && pending_q) begin
               divisor_d = shadow_q;
               pending_d = 1'b0;
            end
            if (acc) begin
               shadow_d  = acc_div;
               pending_d = 1'b1;
            end
            if (rise && !cont_q) begin
               burst_cnt_d = burst_cnt_q - BURST_BITS'(1);
               if (burst_cnt_q == BURST_BITS'(1)) begin
                  state_d = DRAIN;
               end
            end
            if (stop) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!div_clk) begin
               // Leaving: anything outstanding goes straight to the divider.
               state_d = IDLE;
               if (pending_q) begin
                  divisor_d = shadow_q;
                  pending_d = 1'b0;
               end
               if (acc) begin
                  divisor_d = acc_div;
               end
            end else begin
               if (rise && pending_q) begin
                  divisor_d = shadow_q;
                  pending_d = 1'b0;
               end
               if (acc) begin
                  shadow_d  = acc_div;
                  pending_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      div_reset_n_d = (state_d != IDLE);
      busy_d        = (state_d != IDLE);
      done_d        = (state_q != IDLE) && (state_d == IDLE);
   end

   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         div_clk_q     <= 1'b0;
         divisor_q     <= BITS'(DEFAULT_DIV);
         shadow_q      <= '0;
         pending_q     <= 1'b0;
         burst_cnt_q   <= '0;
         cont_q        <= 1'b0;
         div_reset_n_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         div_clk_q     <= div_clk;
         divisor_q     <= divisor_d;
         shadow_q      <= shadow_d;
         pending_q     <= pending_d;
         burst_cnt_q   <= burst_cnt_d;
         cont_q        <= cont_d;
         div_reset_n_q <= div_reset_n_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign divisor_out = divisor_q;
   assign div_reset_n = div_reset_n_q;
   assign busy        = busy_q;
   assign pending     = pending_q;
   assign done        = done_q;

endmodule

// File: tb/tb_divider_scheduler.sv
// Bench for divider_scheduler: a behavioural divider plus directed and randomized steps
// whose expectations come from half-period = divisor+1 arithmetic.
module tb_divider_scheduler;

   localparam int unsigned BITS       = 8;
   localparam int unsigned BURST_BITS = 16;
   localparam int unsigned DEF        = 3;

   logic                  clock_in;
   logic                  reset;
   logic                  start;
   logic                  stop;
   logic [BURST_BITS-1:0] burst_len;
   logic                  div_clk;
   logic [BITS-1:0]       divisor_out;
   logic                  div_reset_n;
   logic                  busy;
   logic                  pending;
   logic                  done;
   logic [BITS-1:0]       dcnt;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   done_cnt = 0;
   int   rise_cnt = 0;
   logic dprev = 1'b0;
   logic ptr_m;

   divider_scheduler_if #(.BITS(BITS)) rif ();

   divider_scheduler #(
      .BITS        (BITS),
      .DEFAULT_DIV (DEF),
      .BURST_BITS  (BURST_BITS)
   ) dut (
      .clock_in    (clock_in),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .burst_len   (burst_len),
      .div_clk     (div_clk),
      .req         (rif),
      .divisor_out (divisor_out),
      .div_reset_n (div_reset_n),
      .busy        (busy),
      .pending     (pending),
      .done        (done)
   );

   initial begin
      clock_in = 1'b0;
      forever #5 clock_in = ~clock_in;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1);
   end

   // Behavioural divider: toggles when its counter reaches the divisor.
   always @(posedge clock_in or negedge div_reset_n) begin
      if (!div_reset_n) begin
         dcnt    <= '0;
         div_clk <= 1'b0;
      end else if (dcnt == divisor_out) begin
         dcnt    <= '0;
         div_clk <= ~div_clk;
      end else begin
         dcnt <= dcnt + 8'd1;
      end
   end

   always @(posedge clock_in) cyc <= cyc + 1;

   always @(negedge clock_in) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (div_clk === 1'b1 && dprev === 1'b0) rise_cnt <= rise_cnt + 1;
      dprev <= div_clk;
   end

   // Round-robin pointer: next preferred requester is the one not served last.
   always @(posedge clock_in or negedge reset) begin
      if (!reset) ptr_m <= 1'b0;
      else if (rif.a_valid && rif.a_ready) ptr_m <= 1'b1;
      else if (rif.b_valid && rif.b_ready) ptr_m <= 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [BITS-1:0] clamp(input logic [BITS-1:0] v);
      return (v == '0) ? 8'd1 : v;
   endfunction

   // Finds the next cycle where div_clk reaches lvl, starting with the current cycle.
   task automatic wait_div(input logic lvl, input logic prev0, input int budget,
                           output int stamp, output logic ok);
      logic p;
      p = prev0;
      ok = 1'b0;
      stamp = -1;
      for (int i = 0; i < budget; i++) begin
         if (div_clk === lvl && p !== lvl) begin
            stamp = cyc;
            ok = 1'b1;
            break;
         end
         p = div_clk;
         @(negedge clock_in);
      end
   endtask

   task automatic request(input bit use_b, input logic [BITS-1:0] val, input int budget,
                          output logic ok, output logic prev_c);
      ok = 1'b0;
      prev_c = div_clk;
      if (use_b) begin rif.b_valid = 1'b1; rif.b_divisor = val; end
      else       begin rif.a_valid = 1'b1; rif.a_divisor = val; end
      for (int i = 0; i < budget; i++) begin
         #1;
         if ((use_b ? rif.b_ready : rif.a_ready) === 1'b1) begin
            ok = 1'b1;
            prev_c = div_clk;
            @(negedge clock_in);
            break;
         end
         @(negedge clock_in);
      end
      rif.a_valid = 1'b0;
      rif.b_valid = 1'b0;
   endtask

   task automatic idle_load(input logic [BITS-1:0] val);
      logic ok, p;
      request(1'b0, val, 4, ok, p);
      check("idle_load_ack", 32'(ok), 1);
      check("idle_load_div", 32'(divisor_out), 32'(clamp(val)));
   endtask

   task automatic start_run(input int len, output int n);
      burst_len = BURST_BITS'(len);
      start = 1'b1;
      n = cyc;
      @(negedge clock_in);
      start = 1'b0;
   endtask

   // After an accepted run-time request: the next rise applies it to the whole period.
   task automatic expect_applied(input string tag, input logic prev_c, input int exp);
      int r1, f1, r2;
      logic ok1, ok2, ok3;
      wait_div(1'b1, prev_c, 80, r1, ok1);
      wait_div(1'b0, div_clk, 80, f1, ok2);
      wait_div(1'b1, div_clk, 80, r2, ok3);
      check({tag, "_edges"}, 32'(ok1 & ok2 & ok3), 1);
      check({tag, "_high"}, 32'(f1 - r1), 32'(exp + 1));
      check({tag, "_low"}, 32'(r2 - f1), 32'(exp + 1));
      check({tag, "_div"}, 32'(divisor_out), 32'(exp));
   endtask

   initial begin
      int n, r, f, r_prev, d_st, s, cur_div, len, r0, dn0, t_prev, t_now;
      logic ok, ok2, pc, lvl, got;
      logic [BITS-1:0] va, vb, v;
      bit av, bv, use_b;

      reset = 1'b0; start = 1'b0; stop = 1'b0; burst_len = '0;
      rif.a_valid = 1'b1; rif.b_valid = 1'b1;
      rif.a_divisor = 8'd5; rif.b_divisor = 8'd9;
      repeat (2) @(negedge clock_in);

      check("rst_divisor", 32'(divisor_out), DEF);
      check("rst_div_reset_n", 32'(div_reset_n), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_done", 32'(done), 0);
      check("rst_a_ready", 32'(rif.a_ready), 0);
      check("rst_b_ready", 32'(rif.b_ready), 0);
      rif.a_valid = 1'b0; rif.b_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock_in);

      // Directed arbitration: A first, then B, divisor ends at 9.
      rif.a_valid = 1'b1; rif.b_valid = 1'b1;
      #1;
      check("arb_first_a", 32'(rif.a_ready), 1);
      check("arb_first_b", 32'(rif.b_ready), 0);
      @(negedge clock_in);
      rif.a_valid = 1'b0;
      #1;
      check("arb_second_b", 32'(rif.b_ready), 1);
      check("arb_div_5", 32'(divisor_out), 5);
      @(negedge clock_in);
      rif.b_valid = 1'b0;
      check("arb_div_9", 32'(divisor_out), 9);

      // Randomized IDLE arbitration against the pointer model.
      for (int i = 0; i < 8; i++) begin
         av = 1'($urandom_range(0, 1));
         bv = 1'($urandom_range(0, 1));
         if (!av && !bv) begin av = 1'b1; bv = 1'b1; end
         va = 8'($urandom_range(1, 255));
         vb = 8'($urandom_range(1, 255));
         rif.a_valid = av; rif.a_divisor = va;
         rif.b_valid = bv; rif.b_divisor = vb;
         use_b = (av && bv) ? ptr_m : bv;
         #1;
         check("rr_a_ready", 32'(rif.a_ready), 32'(!use_b));
         check("rr_b_ready", 32'(rif.b_ready), 32'(use_b));
         @(negedge clock_in);
         rif.a_valid = 1'b0; rif.b_valid = 1'b0;
         check("rr_div", 32'(divisor_out), 32'(use_b ? vb : va));
      end

      // Clamp of a zero request.
      request(1'b1, 8'd0, 4, ok, pc);
      check("clamp_ack", 32'(ok), 1);
      check("clamp_div", 32'(divisor_out), 1);

      // Continuous run at divisor 3.
      idle_load(8'd3);
      dn0 = done_cnt;
      start_run(0, n);
      check("cont_busy", 32'(busy), 1);
      check("cont_div_reset_n", 32'(div_reset_n), 1);
      wait_div(1'b1, div_clk, 40, r, ok);
      check("cont_first_rise_found", 32'(ok), 1);
      check("cont_first_rise_time", 32'(r), 32'(n + 3 + 2));
      r_prev = r;
      for (int i = 0; i < 3; i++) begin
         wait_div(1'b0, div_clk, 40, f, ok);
         wait_div(1'b1, div_clk, 40, r, ok2);
         check("cont_high", 32'(f - r_prev), 4);
         check("cont_period", 32'(r - r_prev), 8);
         r_prev = r;
      end
      check("cont_no_done", 32'(done_cnt - dn0), 0);

      // Glitch-free change: go to 7, then request 1 in the middle of a high phase.
      request(1'b0, 8'd7, 40, ok, pc);
      check("gl_ack7", 32'(ok), 1);
      expect_applied("gl_to7", pc, 7);
      repeat (3) @(negedge clock_in);
      request(1'b0, 8'd1, 4, ok, pc);
      check("gl_ack1", 32'(ok), 1);
      check("gl_pending", 32'(pending), 1);
      wait_div(1'b1, pc, 40, r, ok);
      check("gl_rise_found", 32'(ok), 1);
      check("gl_div_at_rise", 32'(divisor_out), 7);
      @(negedge clock_in);
      check("gl_div_after_rise", 32'(divisor_out), 1);
      check("gl_pending_clear", 32'(pending), 0);
      t_prev = r;
      lvl = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_div(lvl, ~lvl, 20, t_now, ok);
         check("gl_half_period", 32'(t_now - t_prev), 2);
         t_prev = t_now;
         lvl = ~lvl;
      end
      cur_div = 1;

      // Randomized run-time divisor changes from either requester.
      for (int i = 0; i < 6; i++) begin
         v = 8'($urandom_range(0, 6));
         use_b = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 5)) @(negedge clock_in);
         request(use_b, v, 60, ok, pc);
         check("rnd_ack", 32'(ok), 1);
         expect_applied("rnd", pc, 32'(clamp(v)));
         cur_div = 32'(clamp(v));
      end

      // Stop while the output is high: it must finish the high phase first.
      wait_div(1'b1, div_clk, 40, r, ok);
      @(negedge clock_in);
      check("stop_high_at_stop", 32'(div_clk), 1);
      stop = 1'b1;
      s = cyc;
      @(negedge clock_in);
      stop = 1'b0;
      wait_div(1'b0, 1'b1, 40, f, ok);
      check("stop_fall_found", 32'(ok), 1);
      check("stop_still_running", 32'(div_reset_n), 1);
      check("stop_no_early_done", 32'(done), 0);
      @(negedge clock_in);
      check("stop_done", 32'(done), 1);
      check("stop_div_reset_n", 32'(div_reset_n), 0);
      check("stop_busy", 32'(busy), 0);
      check("stop_latency", 32'((cyc - s) <= (cur_div + 1 + 2)), 1);
      @(negedge clock_in);
      check("stop_done_pulse", 32'(done), 0);

      // Start and stop together in IDLE: stays idle.
      start = 1'b1; stop = 1'b1;
      @(negedge clock_in);
      start = 1'b0; stop = 1'b0;
      check("ss_busy", 32'(busy), 0);
      check("ss_div_reset_n", 32'(div_reset_n), 0);

      // Bursts: directed 3/4, then random divisor and length.
      for (int k = 0; k < 3; k++) begin
         v   = (k == 0) ? 8'd3 : 8'($urandom_range(1, 5));
         len = (k == 0) ? 4 : $urandom_range(1, 6);
         idle_load(v);
         r0 = rise_cnt;
         dn0 = done_cnt;
         start_run(len, n);
         wait_div(1'b1, div_clk, 40, r, ok);
         check("burst_first_rise", 32'(r), 32'(n + 32'(v) + 2));
         for (int i = 1; i < len; i++) begin
            wait_div(1'b1, div_clk, 40, r, ok);
            check("burst_rise_found", 32'(ok), 1);
         end
         got = 1'b0;
         d_st = -1;
         for (int i = 0; i < 60; i++) begin
            @(negedge clock_in);
            if (done === 1'b1) begin got = 1'b1; d_st = cyc; break; end
         end
         check("burst_done_seen", 32'(got), 1);
         check("burst_done_time", 32'(d_st), 32'(r + 32'(v) + 2));
         check("burst_end_low", 32'(div_clk), 0);
         check("burst_div_reset_n", 32'(div_reset_n), 0);
         check("burst_busy", 32'(busy), 0);
         repeat (3) @(negedge clock_in);
         check("burst_rises", 32'(rise_cnt - r0), 32'(len));
         check("burst_one_done", 32'(done_cnt - dn0), 1);
      end

      // Reset mid-run with a pending divisor: everything back to reset values.
      idle_load(8'd4);
      start_run(0, n);
      wait_div(1'b1, div_clk, 40, r, ok);
      request(1'b0, 8'd9, 2, ok, pc);
      check("rr_pend_ack", 32'(ok), 1);
      check("rr_pend_set", 32'(pending), 1);
      reset = 1'b0;
      rif.a_valid = 1'b1; rif.b_valid = 1'b1;
      #1;
      check("mr_divisor", 32'(divisor_out), DEF);
      check("mr_pending", 32'(pending), 0);
      check("mr_busy", 32'(busy), 0);
      check("mr_div_reset_n", 32'(div_reset_n), 0);
      check("mr_done", 32'(done), 0);
      check("mr_a_ready", 32'(rif.a_ready), 0);
      check("mr_b_ready", 32'(rif.b_ready), 0);
      @(negedge clock_in);
      reset = 1'b1;
      #1;
      check("mr_ptr_a", 32'(rif.a_ready), 1);
      check("mr_ptr_b", 32'(rif.b_ready), 0);
      rif.a_valid = 1'b0; rif.b_valid = 1'b0;
      @(negedge clock_in);
      start_run(1, n);
      wait_div(1'b1, div_clk, 40, r, ok);
      check("mr_first_rise", 32'(r), 32'(n + DEF + 2));
      check("mr_no_shadow", 32'(pending), 0);
      @(negedge clock_in);
      check("mr_div_default", 32'(divisor_out), DEF);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock_in);
         if (done === 1'b1) begin got = 1'b1; break; end
      end
      check("mr_done_seen", 32'(got), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
